// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner front end.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    function automatic logic one_low(input logic [3:0] row);
        int unsigned zeros;
        zeros = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!row[i]) zeros++;
        end
        return zeros == 1;
    endfunction

    // Only meaningful for patterns accepted by one_low().
    function automatic logic [1:0] low_index(input logic [3:0] row);
        case (row)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'hA;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hB;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'hA: return 4'h9;
            4'hB: return 4'hC;
            4'hC: return 4'hE;
            4'hD: return 4'h0;
            4'hE: return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer with synchronous reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, row debounce, one key_valid pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [1:0] col_idx,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CNT);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

    logic [3:0]    row_s;
    logic [3:0]    row_cap;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] db_cnt;
    state_t        state;

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= '0;
            col_n     <= 4'b1110;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            row_cap   <= '1;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else if (!ena) begin
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (one_low(row_s)) begin
                            row_cap <= row_s;
                            db_cnt  <= '0;
                            state   <= PRESS_DB;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_n   <= col_drive(col_idx + 2'd1);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SW'(1);
                    end
                end
                PRESS_DB: begin
                    if (row_s != row_cap) begin
                        // Bounce: give up on this column and move on rather than rescanning it.
                        state    <= SCAN;
                        scan_cnt <= '0;
                        col_idx  <= col_idx + 2'd1;
                        col_n    <= col_drive(col_idx + 2'd1);
                    end else if (db_cnt == DB_LAST) begin
                        state     <= HELD;
                        key_code  <= key_map(low_index(row_cap), col_idx);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (row_s == 4'hF) begin
                        db_cnt <= '0;
                        state  <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (row_s != 4'hF) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state    <= SCAN;
                        col_idx  <= '0;
                        col_n    <= 4'b1110;
                        scan_cnt <= '0;
                        key_held <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic       ena;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [1:0] col_idx;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] pressed [4];
    logic [3:0] force_low;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int doubles = 0;
    logic prev_valid = 1'b0;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .row_n     (row_n),
        .col_n     (col_n),
        .col_idx   (col_idx),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low only while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (((pressed[r] & ~col_n) != 4'h0) || force_low[r]) row_n[r] = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) pulses++;
        if (key_valid && prev_valid) doubles++;
        prev_valid = key_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        force_low = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ena   = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!key_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, key_valid, 1);
    endtask

    task automatic wait_release(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (key_held && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, key_held, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int found;
        clear_keys();
        reset = 1'b1;
        ena   = 1'b1;
        @(negedge clk);

        // Reset state and idle scan sequence.
        repeat (3) tick();
        check("rst_col_n", col_n, 4'b1110);
        check("rst_col_idx", col_idx, 0);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            check($sformatf("idle_col_%0d", i), col_n, exp_col);
            tick();
        end
        check("idle_pulses", pulses, 0);
        check("idle_held", key_held, 0);

        // Clean press row 1 / col 2, held from reset release.
        clear_keys();
        pressed[1][2] = 1'b1;
        do_reset();
        p0 = pulses;
        found = -1;
        for (int i = 0; i < 40; i++) begin
            if (key_valid) begin
                found = i;
                break;
            end
            tick();
        end
        check("press_latency", found, 20);
        check("press_code", key_code, 4'h6);
        check("press_held", key_held, 1);
        pressed[1][2] = 1'b0;
        tick();
        check("press_one_cycle", key_valid, 0);
        repeat (9) tick();
        check("release_held_before", key_held, 1);
        tick();
        check("release_held_after", key_held, 0);
        check("release_col_idx", col_idx, 0);
        check("release_col_n", col_n, 4'b1110);
        repeat (4) tick();
        check("rescan_col_idx", col_idx, 1);
        check("press_pulses", pulses - p0, 1);

        // Bounce on row 2 / col 1, then stable.
        clear_keys();
        do_reset();
        p0 = pulses;
        for (int t = 0; t < 7; t++) begin
            pressed[2][1] = ~pressed[2][1];
            repeat (3) tick();
        end
        check("bounce_no_pulse", pulses - p0, 0);
        pressed[2][1] = 1'b1;
        wait_pulse("bounce_pulse", 40);
        check("bounce_code", key_code, 4'h8);
        check("bounce_pulses", pulses - p0, 1);
        clear_keys();
        wait_release("bounce_release", 40);

        // Two keys in column 0, then row 2 released.
        do_reset();
        p0 = pulses;
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        repeat (40) tick();
        check("dual_no_pulse", pulses - p0, 0);
        check("dual_no_held", key_held, 0);
        pressed[2][0] = 1'b0;
        wait_pulse("dual_pulse", 40);
        check("dual_code", key_code, 4'h1);
        clear_keys();
        wait_release("dual_release", 40);

        // Release glitch at RELEASE_DB count 5 (row 3 / col 3).
        do_reset();
        pressed[3][3] = 1'b1;
        wait_pulse("glitch_pulse", 40);
        check("glitch_code", key_code, 4'hD);
        p0 = pulses;
        pressed[3][3] = 1'b0;
        repeat (6) tick();
        force_low[3] = 1'b1;
        tick();
        force_low[3] = 1'b0;
        repeat (10) tick();
        check("glitch_held_before", key_held, 1);
        tick();
        check("glitch_held_after", key_held, 0);
        check("glitch_no_repeat", pulses - p0, 0);

        // ena low from debounce count 4 (row 0 / col 1), then reset while HELD.
        clear_keys();
        pressed[0][1] = 1'b1;
        do_reset();
        p0 = pulses;
        repeat (12) tick();
        ena = 1'b0;
        repeat (10) tick();
        check("ena_col_idx", col_idx, 1);
        check("ena_col_n", col_n, 4'b1101);
        check("ena_valid", key_valid, 0);
        check("ena_held", key_held, 0);
        check("ena_no_pulse", pulses - p0, 0);
        ena = 1'b1;
        repeat (3) tick();
        check("ena_resume_early", key_valid, 0);
        tick();
        check("ena_resume_pulse", key_valid, 1);
        check("ena_resume_code", key_code, 4'h2);
        check("ena_resume_held", key_held, 1);
        tick();
        p0 = pulses;
        reset = 1'b1;
        tick();
        check("held_rst_held", key_held, 0);
        check("held_rst_code", key_code, 0);
        check("held_rst_valid", key_valid, 0);
        reset = 1'b0;
        tick();
        check("held_rst_no_pulse", pulses - p0, 0);
        clear_keys();
        repeat (4) tick();

        check("no_double_pulse", doubles, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low hex keypad matrix, synchronizes and debounces the row inputs, and emits one 4-bit hex key code per debounced press. It sits directly upstream of the register bank: `key_code` is zero-extended to 8 bits as register write data, and `key_valid` is the write strobe. It replaces the free-running column counter and combinational encoder pair with a single stateful front end.

## Interface
- `SCAN_DIV`, default 16: clock cycles each column stays driven; minimum 4.
- `DEBOUNCE_CNT`, default 1024: consecutive stable synchronized samples required for a press and for a release; minimum 2.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `ena`  in  1  scan enable; when low, all state freezes
- `row_n`  in  4  keypad rows, active low, asynchronous, pulled up externally
- `col_n`  out  4  column drives, active-low one-hot
- `col_idx`  out  2  index of the currently driven column
- `key_code`  out  4  last debounced key code, held until the next press
- `key_valid`  out  1  one-cycle pulse when a new `key_code` is presented
- `key_held`  out  1  high while a debounced key remains pressed

## Operation
- Rows pass through a 2-flop synchronizer (`row_s`). All decisions use `row_s` only.
- State machine states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - `col_idx` advances 0→1→2→3→0 every `SCAN_DIV` cycles.
  - `col_n` = ~(1<<col_idx).
  - The sample point is the last cycle of each column period.
  - At the sample point, if exactly one bit of `row_s` is low, capture `row_s`, freeze the column, and go to PRESS_DB with the counter at 0.
  - If zero or two or more bits of `row_s` are low, ignore the sample and keep scanning.
- PRESS_DB:
  - Each cycle `row_s` equals the captured pattern, the counter increments.
  - Any mismatch returns to SCAN, resuming at the next column.
  - On the `DEBOUNCE_CNT`-th consecutive match, go to HELD. In the same registered update, `key_code` loads the mapped value and `key_valid` pulses.
- HELD:
  - `key_held` = 1 and the column stays frozen.
  - When `row_s` == 4'hF, go to RELEASE_DB with the counter at 0.
- RELEASE_DB:
  - Requires `DEBOUNCE_CNT` consecutive `row_s` == 4'hF samples.
  - Any low row returns to HELD.
  - On completion, go to SCAN with `col_idx` = 0 and the scan counter at 0. `key_held` stays 1 until this exit.
- Key map, (row, col) → code:
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E, 0, F, D
- `ena` low:
  - Counters, state, and `col_n` hold their values.
  - `key_valid` is forced to 0. A press completing while `ena` is low is deferred until `ena` returns high.
  - The synchronizer keeps running.
- Only one press is reported per physical press. Auto-repeat is not supported.

## Timing
- Reset values:
  - state SCAN, `col_idx` = 0, `col_n` = 4'b1110
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0
  - counters and synchronizer = 0
- `reset` overrides `ena`. Reset during PRESS_DB or HELD discards the press and raises no `key_valid`.
- Press latency, measured from the rising edge where `row_s` first shows the key at a sample point: `DEBOUNCE_CNT` + 1 cycles to `key_valid`. Add 2 cycles of synchronizer delay from the pin.
- Worst-case detection delay is 4·`SCAN_DIV` cycles.
- `key_valid` is exactly 1 cycle wide and never asserts on two consecutive cycles.
- All outputs are registered. `col_n` is a pure function of `col_idx`.
- Counters are wide enough for `DEBOUNCE_CNT` and `SCAN_DIV`, and never wrap inside a debounce window.

## Structure
- Package `keypad_pkg` holds:
  - the state enum
  - the 16-entry key map as a constant function `key_map(row, col)`
  - a `one_low(row)` helper that returns "exactly one bit low"
- Sub-module `sync2`: a parameterized-width 2-flop synchronizer with synchronous reset, instantiated once for `row_n`.
- The top-level wrapper replaces the existing counter and encoder. It ties `uio_oe`[5:4] to outputs carrying `col_idx`, feeds `key_valid` into the register-bank write enable, and drives `{4'b0, key_code}` as write data.

## Test plan
Use `SCAN_DIV` = 4 and `DEBOUNCE_CNT` = 8 throughout.
- Reset, no keys: after reset release, `col_n` cycles 1110→1101→1011→0111 with 4 cycles per column; `key_valid` and `key_held` stay 0.
- Clean press of row 1 / col 2, modelled to pull the row low only while col 2 is driven: exactly one `key_valid` pulse with `key_code` = 4'h6. `key_held` = 1 until 8 cycles after release, then scanning restarts at col 0.
- Bounce: the row toggles every 3 cycles for 20 cycles, then stays stable. There is no pulse during the bounce, then one pulse with the correct code 9 cycles after the last sample-point detection.
- Two keys in the same column (rows 0 and 2, col 0): no pulse while both are held. Releasing row 2 yields `key_code` = 4'h1.
- Release glitch: in RELEASE_DB, the row goes low for 1 cycle at count 5. The FSM returns to HELD, no second `key_valid` occurs, and full release then completes normally.
- `ena` and reset: with `ena` = 0 from debounce count 4, all outputs freeze; re-enabling completes with a pulse. Asserting `reset` at HELD clears `key_held` and `key_code` to 0 on the next cycle with no pulse.
